// File: rtl/wash_exec.sv
// Execution core of the washing register machine: fetches from a combinational ROM, runs loop registers and timed actuator steps.
// Optional door interlock is enabled by defining WASH_DOOR_INTERLOCK_EN (adds the door_open input).
module wash_exec #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 32,
  parameter int REG_COUNT   = 4,
  parameter int ENTRY_PC    = 2,
  parameter int PHASE_REG   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   tick,
`ifdef WASH_DOOR_INTERLOCK_EN
  input  logic                   door_open,
`endif
  output logic [ADDR_WIDTH-1:0]  pc,
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic                   valve_fill,
  output logic                   valve_drn,
  output logic                   motor_fwd,
  output logic                   motor_rev,
  output logic [15:0]            phase,
  output logic                   busy,
  output logic                   halted,
  output logic                   fault
);

  localparam int              RIW       = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [7:0]      REG_LIMIT = 8'(REG_COUNT);
  localparam logic [ADDR_WIDTH-1:0] ENTRY = ADDR_WIDTH'(ENTRY_PC);

  localparam logic [7:0] OP_HALT    = 8'h00;
  localparam logic [7:0] OP_WAIT    = 8'h11;
  localparam logic [7:0] OP_FILL    = 8'h12;
  localparam logic [7:0] OP_RELEASE = 8'h13;
  localparam logic [7:0] OP_FORWARD = 8'h14;
  localparam logic [7:0] OP_REVERSE = 8'h15;
  localparam logic [7:0] OP_SET     = 8'h21;
  localparam logic [7:0] OP_DEC     = 8'h22;
  localparam logic [7:0] OP_J       = 8'h30;
  localparam logic [7:0] OP_JZ      = 8'h31;
  localparam logic [7:0] OP_JNZ     = 8'h32;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_TIMED, S_HALT, S_FAULT} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [15:0]             r_q [REG_COUNT];
  logic [15:0]             cnt_q;
  logic [7:0]              top_q;
  logic [3:0]              act_q;  // {fill, drn, fwd, rev}
  logic                    door_hold;

`ifdef WASH_DOOR_INTERLOCK_EN
  logic door_s1_q, door_s2_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      door_s1_q <= 1'b0;
      door_s2_q <= 1'b0;
    end else begin
      door_s1_q <= door_open;
      door_s2_q <= door_s1_q;
    end
  end
  assign door_hold = door_s2_q;
`else
  assign door_hold = 1'b0;
`endif

  logic [7:0]            op;
  logic [7:0]            rsel;
  logic [15:0]           imm;
  logic [RIW-1:0]        ridx;
  logic                  reg_ok;
  logic [15:0]           rval;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] jmp_pc;

  assign op     = instr[7:0];
  assign rsel   = instr[15:8];
  assign imm    = instr[31:16];
  assign ridx   = rsel[RIW-1:0];
  assign reg_ok = (rsel < REG_LIMIT);
  assign rval   = r_q[ridx];
  assign pc_inc = pc_q + 1'b1;
  assign jmp_pc = imm[ADDR_WIDTH-1:0];

  // While the door is open only the drain valve may stay on.
  function automatic logic [3:0] act_of(input logic [7:0] o, input logic hold);
    logic [3:0] a;
    a = 4'b0000;
    case (o)
      OP_FILL:    a = hold ? 4'b0000 : 4'b1000;
      OP_RELEASE: a = 4'b0100;
      OP_FORWARD: a = hold ? 4'b0000 : 4'b0010;
      OP_REVERSE: a = hold ? 4'b0000 : 4'b0001;
      default:    a = 4'b0000;
    endcase
    return a;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= ENTRY;
      cnt_q   <= '0;
      top_q   <= OP_WAIT;
      act_q   <= '0;
      for (int i = 0; i < REG_COUNT; i++) r_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_HALT, S_FAULT: begin
          if (start && !door_hold) begin
            state_q <= S_EXEC;
            pc_q    <= ENTRY;
            cnt_q   <= '0;
            for (int i = 0; i < REG_COUNT; i++) r_q[i] <= '0;
          end
        end
        S_EXEC: begin
          case (op)
            OP_HALT: state_q <= S_HALT;
            OP_SET: begin
              if (reg_ok) begin
                r_q[ridx] <= imm;
                pc_q      <= pc_inc;
              end else begin
                state_q <= S_FAULT;
              end
            end
            OP_DEC: begin
              if (reg_ok) begin
                r_q[ridx] <= rval - 16'd1;
                pc_q      <= pc_inc;
              end else begin
                state_q <= S_FAULT;
              end
            end
            OP_J: pc_q <= jmp_pc;
            OP_JZ, OP_JNZ: begin
              if (!reg_ok)                            state_q <= S_FAULT;
              else if ((rval == 16'd0) == (op == OP_JZ)) pc_q <= jmp_pc;
              else                                    pc_q <= pc_inc;
            end
            OP_WAIT, OP_FILL, OP_RELEASE, OP_FORWARD, OP_REVERSE: begin
              if (imm == 16'd0) begin
                pc_q <= pc_inc;
              end else begin
                cnt_q   <= imm;
                top_q   <= op;
                act_q   <= act_of(op, door_hold);
                state_q <= S_TIMED;
              end
            end
            default: state_q <= S_FAULT;
          endcase
        end
        S_TIMED: begin
          act_q <= act_of(top_q, door_hold);
          if (tick && !door_hold) begin
            if (cnt_q <= 16'd1) begin
              cnt_q   <= '0;
              act_q   <= '0;
              pc_q    <= pc_inc;
              state_q <= S_EXEC;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pc         = pc_q;
  assign valve_fill = act_q[3];
  assign valve_drn  = act_q[2];
  assign motor_fwd  = act_q[1];
  assign motor_rev  = act_q[0];
  assign phase      = r_q[PHASE_REG];
  assign busy       = (state_q == S_EXEC) || (state_q == S_TIMED);
  assign halted     = (state_q == S_HALT);
  assign fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_wash_exec.sv
// Directed bench for wash_exec: small ROM programs with hand-computed expectations.
module tb_wash_exec;
  logic        clk = 1'b0;
  logic        rst_n, start, tick;
  logic [7:0]  pc;
  logic [31:0] instr;
  logic        valve_fill, valve_drn, motor_fwd, motor_rev;
  logic [15:0] phase;
  logic        busy, halted, fault;
`ifdef WASH_DOOR_INTERLOCK_EN
  logic        door_open;
`endif

  logic [31:0] rom [256];
  int vectors = 0;
  int miscompares = 0;
  int fwd_pulses = 0;
  int base;
  logic fwd_prev = 1'b0;

  assign instr = rom[pc];

  wash_exec dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tick(tick),
`ifdef WASH_DOOR_INTERLOCK_EN
    .door_open(door_open),
`endif
    .pc(pc), .instr(instr),
    .valve_fill(valve_fill), .valve_drn(valve_drn),
    .motor_fwd(motor_fwd), .motor_rev(motor_rev),
    .phase(phase), .busy(busy), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (motor_fwd && !fwd_prev) fwd_pulses <= fwd_pulses + 1;
    fwd_prev <= motor_fwd;
  end

  localparam logic [7:0] HALT = 8'h00, WAIT = 8'h11, FILL = 8'h12, FWD = 8'h14,
                         REV = 8'h15, SET = 8'h21, DEC = 8'h22, J = 8'h30,
                         JZ = 8'h31, JNZ = 8'h32;

  function automatic logic [31:0] enc(input logic [7:0] o, input logic [7:0] rg,
                                      input logic [15:0] im);
    return {im, rg, o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cycles(1);
    tick = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tick = 1'b0;
`ifdef WASH_DOOR_INTERLOCK_EN
    door_open = 1'b0;
`endif
    clear_rom();
    cycles(3);
    chk("rst_pc", pc, 8'd2);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_phase", phase, 16'd0);
    chk("rst_act", {valve_fill, valve_drn, motor_fwd, motor_rev}, 4'b0000);
    rst_n = 1'b1;
    cycles(2);
    chk("idle_busy", busy, 1'b0);

    // Test 1: SET r2=1; FILL 3; HALT. Ticks during EXEC are ignored.
    rom[2] = enc(SET, 8'd2, 16'd1);
    rom[3] = enc(FILL, 8'd0, 16'd3);
    rom[4] = enc(HALT, 8'd0, 16'd0);
    pulse_start();
    chk("t1_busy", busy, 1'b1);
    chk("t1_pc_entry", pc, 8'd2);
    tick = 1'b1;
    cycles(1);
    chk("t1_phase", phase, 16'd1);
    chk("t1_pc3", pc, 8'd3);
    cycles(1);
    tick = 1'b0;
    chk("t1_fill_on", valve_fill, 1'b1);
    cycles(2);
    chk("t1_fill_hold", valve_fill, 1'b1);
    pulse_tick();
    cycles(1);
    pulse_tick();
    chk("t1_fill_tick2", valve_fill, 1'b1);
    pulse_tick();
    chk("t1_fill_off", valve_fill, 1'b0);
    chk("t1_pc4", pc, 8'd4);
    cycles(1);
    chk("t1_halted", halted, 1'b1);
    chk("t1_busy_off", busy, 1'b0);
    cycles(2);
    chk("t1_pc_hold", pc, 8'd4);

    // Test 2: loop on r2 (visible on phase) around FORWARD 1.
    clear_rom();
    rom[2] = enc(SET, 8'd2, 16'd2);
    rom[3] = enc(FWD, 8'd3, 16'd1);
    rom[4] = enc(DEC, 8'd2, 16'd0);
    rom[5] = enc(JNZ, 8'd2, 16'd3);
    base = fwd_pulses;
    pulse_start();
    chk("t2_phase_clr", phase, 16'd0);
    cycles(2);
    chk("t2_fwd1", motor_fwd, 1'b1);
    chk("t2_phase2", phase, 16'd2);
    pulse_start();
    chk("t2_busy_start_pc", pc, 8'd3);
    chk("t2_busy_start_fwd", motor_fwd, 1'b1);
    chk("t2_busy_start_phase", phase, 16'd2);
    pulse_tick();
    chk("t2_fwd1_off", motor_fwd, 1'b0);
    cycles(3);
    chk("t2_fwd2", motor_fwd, 1'b1);
    chk("t2_phase1", phase, 16'd1);
    pulse_tick();
    cycles(3);
    chk("t2_halted", halted, 1'b1);
    chk("t2_pc6", pc, 8'd6);
    chk("t2_phase0", phase, 16'd0);
    chk("t2_pulses", 32'(fwd_pulses - base), 32'd2);

    // Test 3: DEC wrap, JZ both ways, J with upper imm bits, WAIT 0, pc wrap.
    clear_rom();
    rom[2]    = enc(DEC, 8'd2, 16'd0);
    rom[3]    = enc(JZ, 8'd2, 16'h0020);
    rom[4]    = enc(SET, 8'd2, 16'd0);
    rom[5]    = enc(JZ, 8'd2, 16'h0030);
    rom[8'h30] = enc(J, 8'd7, 16'hAB40);
    rom[8'h40] = enc(WAIT, 8'd0, 16'd0);
    rom[8'h41] = enc(J, 8'd0, 16'h00FF);
    rom[8'hFF] = enc(SET, 8'd2, 16'd7);
    pulse_start();
    cycles(1);
    chk("t3_dec_wrap", phase, 16'hFFFF);
    chk("t3_pc3", pc, 8'd3);
    cycles(1);
    chk("t3_jz_not_taken", pc, 8'd4);
    cycles(2);
    chk("t3_jz_taken", pc, 8'h30);
    cycles(1);
    chk("t3_j_trunc", pc, 8'h40);
    cycles(1);
    chk("t3_wait0_pc", pc, 8'h41);
    chk("t3_wait0_busy", busy, 1'b1);
    cycles(2);
    chk("t3_pc_wrap", pc, 8'h00);
    chk("t3_phase7", phase, 16'd7);
    cycles(1);
    chk("t3_halted", halted, 1'b1);

    // Test 4: illegal opcode, then SET with reg=5.
    clear_rom();
    rom[2]     = enc(J, 8'd0, 16'h0050);
    rom[8'h50] = enc(SET, 8'd2, 16'd9);
    rom[8'h51] = enc(8'h7F, 8'd0, 16'd0);
    pulse_start();
    cycles(3);
    chk("t4_fault", fault, 1'b1);
    chk("t4_busy", busy, 1'b0);
    chk("t4_pc", pc, 8'h51);
    chk("t4_phase", phase, 16'd9);
    pulse_tick();
    cycles(2);
    chk("t4_pc_frozen", pc, 8'h51);
    pulse_start();
    chk("t4_fault_clr", fault, 1'b0);
    chk("t4_pc_entry", pc, 8'd2);
    chk("t4_phase_clr", phase, 16'd0);
    rom[8'h51] = enc(SET, 8'd5, 16'd3);
    cycles(3);
    chk("t4_badreg_fault", fault, 1'b1);
    chk("t4_badreg_pc", pc, 8'h51);
    chk("t4_badreg_phase", phase, 16'd9);

    // Test 5: reset during REVERSE 10 after 4 ticks.
    clear_rom();
    rom[2] = enc(SET, 8'd2, 16'd5);
    rom[3] = enc(REV, 8'd0, 16'd10);
    pulse_start();
    cycles(2);
    chk("t5_rev_on", motor_rev, 1'b1);
    chk("t5_phase", phase, 16'd5);
    repeat (4) pulse_tick();
    chk("t5_rev_4ticks", motor_rev, 1'b1);
    chk("t5_pc3", pc, 8'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rev_async", motor_rev, 1'b0);
    chk("t5_pc_rst", pc, 8'd2);
    chk("t5_phase_rst", phase, 16'd0);
    chk("t5_busy_rst", busy, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycles(2);
    chk("t5_idle_busy", busy, 1'b0);
    chk("t5_idle_halted", halted, 1'b0);
    chk("t5_idle_pc", pc, 8'd2);

`ifdef WASH_DOOR_INTERLOCK_EN
    // Test 6: door opened mid FORWARD 5.
    clear_rom();
    rom[2] = enc(FWD, 8'd0, 16'd5);
    pulse_start();
    cycles(1);
    chk("t6_fwd_on", motor_fwd, 1'b1);
    repeat (2) pulse_tick();
    door_open = 1'b1;
    cycles(3);
    chk("t6_fwd_open", motor_fwd, 1'b0);
    chk("t6_busy_open", busy, 1'b1);
    repeat (3) pulse_tick();
    chk("t6_fwd_open_ticks", motor_fwd, 1'b0);
    chk("t6_pc_open", pc, 8'd2);
    door_open = 1'b0;
    cycles(3);
    chk("t6_fwd_resume", motor_fwd, 1'b1);
    repeat (2) pulse_tick();
    chk("t6_fwd_rem1", motor_fwd, 1'b1);
    pulse_tick();
    chk("t6_fwd_done", motor_fwd, 1'b0);
    chk("t6_pc3", pc, 8'd3);
    cycles(1);
    chk("t6_halted", halted, 1'b1);
    door_open = 1'b1;
    cycles(3);
    pulse_start();
    chk("t6_start_ignored", halted, 1'b1);
    chk("t6_start_busy", busy, 1'b0);
    door_open = 1'b0;
    cycles(3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
